// File: rtl/sdf_bfly_stage.sv
`default_nettype none
// ============================================================================
// Module      : sdf_bfly_stage
// Description : Radix-2 DIF single-path delay-feedback butterfly stage.
//               A DEPTH-entry feedback delay line holds first-half samples
//               (fill phase). During the butterfly phase the head is combined
//               with the incoming sample: the sum goes out immediately and
//               the difference is fed back into the line. The stored
//               differences come out during the next fill phase or during
//               flush bubbles.
//               Optional macro BFLY_ROUND_EN: outputs are rounded half-up
//               from W+1 to W bits at the output register.
// Revision    : 1.0 - initial release
// ============================================================================
module sdf_bfly_stage #(
    parameter  int W     = 16,
    parameter  int DEPTH = 16,
`ifdef BFLY_ROUND_EN
    localparam int OW    = W
`else
    localparam int OW    = W + 1
`endif
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          din_valid,
    input  logic          bfly_en,
    input  logic          flush,
    input  logic [W-1:0]  din_re,
    input  logic [W-1:0]  din_im,
    output logic          dout_valid,
    output logic [OW-1:0] dout_re,
    output logic [OW-1:0] dout_im,
    output logic          err_underrun
);

    // Internal sample width: one guard bit so sums/diffs of W-bit inputs fit.
    localparam int c_DW = W + 1;

    // Delay line; index DEPTH-1 is the head (oldest entry).
    logic signed [c_DW-1:0] r_line_re [DEPTH];
    logic signed [c_DW-1:0] r_line_im [DEPTH];
    logic        [DEPTH-1:0] r_line_tag;

    logic                   r_dout_valid;
    logic        [OW-1:0]   r_dout_re;
    logic        [OW-1:0]   r_dout_im;
    logic                   r_err;

    logic                   w_adv;
    logic                   w_head_tag;
    logic signed [c_DW-1:0] w_a_re;
    logic signed [c_DW-1:0] w_a_im;
    logic signed [c_DW-1:0] w_b_re;
    logic signed [c_DW-1:0] w_b_im;
    logic signed [c_DW-1:0] w_sum_re;
    logic signed [c_DW-1:0] w_sum_im;
    logic signed [c_DW-1:0] w_diff_re;
    logic signed [c_DW-1:0] w_diff_im;
    logic signed [c_DW-1:0] w_push_re;
    logic signed [c_DW-1:0] w_push_im;
    logic                   w_push_tag;
    logic signed [c_DW-1:0] w_sel_re;
    logic signed [c_DW-1:0] w_sel_im;
    logic                   w_out_valid;
    logic        [OW-1:0]   w_out_re;
    logic        [OW-1:0]   w_out_im;
    logic                   w_underrun;

    // A flush bubble advances the line exactly like a sample, but with b=0.
    assign w_adv      = din_valid | flush;
    assign w_head_tag = r_line_tag[DEPTH-1];

    // Unoccupied head is treated as zero (covers the underrun case).
    assign w_a_re = w_head_tag ? r_line_re[DEPTH-1] : '0;
    assign w_a_im = w_head_tag ? r_line_im[DEPTH-1] : '0;
    assign w_b_re = din_valid ? {din_re[W-1], din_re} : '0;
    assign w_b_im = din_valid ? {din_im[W-1], din_im} : '0;

    // W+1-bit wrap is exact: operands are sign-extended W-bit values.
    assign w_sum_re  = w_a_re + w_b_re;
    assign w_sum_im  = w_a_im + w_b_im;
    assign w_diff_re = w_a_re - w_b_re;
    assign w_diff_im = w_a_im - w_b_im;

    // Fill pushes the new sample; butterfly pushes the difference (always occupied).
    assign w_push_re  = bfly_en ? w_diff_re : w_b_re;
    assign w_push_im  = bfly_en ? w_diff_im : w_b_im;
    assign w_push_tag = bfly_en | din_valid;

    // Fill emits the popped head; butterfly emits the sum.
    assign w_sel_re    = bfly_en ? w_sum_re : w_a_re;
    assign w_sel_im    = bfly_en ? w_sum_im : w_a_im;
    assign w_out_valid = bfly_en | w_head_tag;

    assign w_underrun = w_adv & bfly_en & ~w_head_tag;

`ifdef BFLY_ROUND_EN
    // (x + 1) >>> 1 equals x>>>1 plus the dropped LSB.
    assign w_out_re = w_sel_re[W:1] + {{(W-1){1'b0}}, w_sel_re[0]};
    assign w_out_im = w_sel_im[W:1] + {{(W-1){1'b0}}, w_sel_im[0]};
`else
    assign w_out_re = w_sel_re;
    assign w_out_im = w_sel_im;
`endif

    // Delay line shifts one place toward the head on every advance.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_line_re[i]  <= '0;
                r_line_im[i]  <= '0;
                r_line_tag[i] <= 1'b0;
            end
        end else if (w_adv) begin
            for (int i = DEPTH - 1; i > 0; i--) begin
                r_line_re[i]  <= r_line_re[i-1];
                r_line_im[i]  <= r_line_im[i-1];
                r_line_tag[i] <= r_line_tag[i-1];
            end
            r_line_re[0]  <= w_push_re;
            r_line_im[0]  <= w_push_im;
            r_line_tag[0] <= w_push_tag;
        end
    end

    // Output register plus sticky underrun flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_dout_valid <= 1'b0;
            r_dout_re    <= '0;
            r_dout_im    <= '0;
            r_err        <= 1'b0;
        end else begin
            r_dout_valid <= w_adv & w_out_valid;
            if (w_adv) begin
                r_dout_re <= w_out_re;
                r_dout_im <= w_out_im;
            end
            if (w_underrun) begin
                r_err <= 1'b1;
            end
        end
    end

    assign dout_valid   = r_dout_valid;
    assign dout_re      = r_dout_re;
    assign dout_im      = r_dout_im;
    assign err_underrun = r_err;

endmodule
`default_nettype wire
